// File: rtl/shared_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shared_port_arbiter_pkg
// Shared constants and types for the shared-resource port arbiter.
//   NUM_REQ / SEL_W  : requester count and mux-select width
//   arb_state_e      : arbiter FSM state (idle / resource owned)
//   REQ_*            : requester indices as seen on req/gnt/sel
//   idx_to_onehot()  : convert a requester index to a one-hot grant vector
// -----------------------------------------------------------------------------
package shared_port_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  localparam logic [SEL_W-1:0] REQ_FETCH  = 2'd0;
  localparam logic [SEL_W-1:0] REQ_LSU    = 2'd1;
  localparam logic [SEL_W-1:0] REQ_MULDIV = 2'd2;
  localparam logic [SEL_W-1:0] REQ_DBG    = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Finds the first set bit of the
// request vector searching upward from the pointer, wrapping modulo NUM_REQ.
//   req_i   [NUM_REQ-1:0] : candidate requests
//   ptr_i   [SEL_W-1:0]   : highest-priority index for this search
//   valid_o               : at least one candidate was set
//   idx_o   [SEL_W-1:0]   : index of the winner (equals ptr_i when !valid_o)
// -----------------------------------------------------------------------------
module rr_pick
  import shared_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [SEL_W-1:0]   idx_o
);

  // Scan from lowest priority to highest so the last hit, i.e. the one
  // closest to the pointer, is the value left standing. The SEL_W-bit add
  // wraps naturally, which gives the modulo-NUM_REQ rotation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    valid_o = 1'b0;
    idx_o   = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[ptr_i + SEL_W'(k)]) begin
        valid_o = 1'b1;
        idx_o   = ptr_i + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// -----------------------------------------------------------------------------
// shared_port_arbiter
// Round-robin arbiter for a 4-requester single-ported resource. Grants one
// owner at a time, holds the grant until the resource signals completion, and
// hands over to the next requester on the same edge (no idle bubble).
//   clk                : rising-edge clock
//   rst                : synchronous, active-high reset
//   req     [3:0]      : request vector, bit i = requester i
//   done               : resource finished the current owner's access
//   gnt     [3:0]      : registered one-hot grant, zero when idle
//   sel     [1:0]      : registered mux select, index of the owner
//   busy               : registered, high while a grant is active
//   timeout            : one-cycle pulse when the watchdog forces a release
// Optional feature: define ARB_TIMEOUT_EN to build the ownership watchdog
// (limit MAX_HOLD cycles). Without it timeout is tied low.
// -----------------------------------------------------------------------------
module shared_port_arbiter
  import shared_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("shared_port_arbiter: MAX_HOLD must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;

  logic               force_rel;
  logic               release_own;
  logic [NUM_REQ-1:0] pick_req;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_q, hold_d;

  // done has priority: a completion on the last allowed cycle is a normal
  // release, not a watchdog event.
  assign force_rel = (state_q == ARB_OWN) && !done &&
                     (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Counts consecutive cycles of the same owner; any grant change restarts it.
  assign hold_d = (state_q == ARB_OWN && !release_own) ? hold_q + HOLD_W'(1)
                                                       : '0;
`else
  assign force_rel = 1'b0;
`endif

  assign release_own = (state_q == ARB_OWN) && (done || force_rel);

  // On release the pointer moves past the owner and the owner's own request
  // is masked, so the same-cycle re-arbitration cannot hand it straight back.
  assign ptr_d    = release_own ? sel_q + SEL_W'(1) : ptr_q;
  assign pick_req = release_own ? (req & ~gnt_q) : req;

  rr_pick u_rr_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_d),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Arbitration happens only when nobody owns the resource or the owner is
  // being released; while owned, req changes are ignored. sel keeps its last
  // value when going idle so the mux never swings to an unrelated input.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    if (state_q == ARB_IDLE || release_own) begin
      if (pick_valid) begin
        state_d = ARB_OWN;
        gnt_d   = idx_to_onehot(pick_idx);
        sel_d   = pick_idx;
        busy_d  = 1'b1;
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = force_rel;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_port_arbiter
// Self-checking bench for shared_port_arbiter: a directed vector table for the
// documented corner cases, a bounded fairness sequence, randomized traffic
// against a behavioural round-robin model, and (when ARB_TIMEOUT_EN is
// defined) a watchdog sequence on a second instance with MAX_HOLD = 4.
// -----------------------------------------------------------------------------
module tb_shared_port_arbiter;
  import shared_port_arbiter_pkg::*;

  localparam int TB_MAX_HOLD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   req;
  logic         done;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         busy;
  logic         timeout;

  shared_port_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: owner index (-1 = idle), round-robin pointer, last
  // select value and ownership age, updated once per clock edge.
  // ---------------------------------------------------------------------------
  int m_owner, m_ptr, m_sel, m_hold;

  function automatic bit model_timeout(input logic d);
`ifdef ARB_TIMEOUT_EN
    return (m_owner >= 0) && !d && (m_hold == TB_MAX_HOLD - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
    bit         rel;
    logic [3:0] cand;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
      return;
    end
    rel = (m_owner >= 0) && (d || model_timeout(d));
    if (m_owner >= 0 && !rel) begin
      m_hold++;
      return;
    end
    cand = r;
    if (rel) begin
      cand[m_owner] = 1'b0;
      m_ptr = (m_owner + 1) % 4;
    end
    m_owner = -1;
    m_hold  = 0;
    for (int k = 0; k < 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (cand[i] && m_owner < 0) begin
        m_owner = i;
        m_sel   = i;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs applied before an edge, outputs expected
  // just after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic [3:0] r, input logic d,
                     input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.rst = rs; v.req = r; v.done = d; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endtask

`ifdef ARB_TIMEOUT_EN
  logic       rst4, done4, busy4, timeout4;
  logic [3:0] req4, gnt4;
  logic [1:0] sel4;

  shared_port_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst4),
    .req     (req4),
    .done    (done4),
    .gnt     (gnt4),
    .sel     (sel4),
    .busy    (busy4),
    .timeout (timeout4)
  );
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int cnt;
    rst = 1'b1; req = 4'b0000; done = 1'b0;
`ifdef ARB_TIMEOUT_EN
    rst4 = 1'b1; req4 = 4'b0000; done4 = 1'b0;
`endif

    // Single owner held while done stays low, then released to idle.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0100, 0, 4'b0100, REQ_MULDIV, 1);
    for (int i = 0; i < 5; i++) add(0, 4'b0100, 0, 4'b0100, REQ_MULDIV, 1);
    add(0, 4'b0000, 1, 4'b0000, REQ_MULDIV, 0);
    // All requesting, done every 2nd cycle: 0,1,2,3,0 without bubbles.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 0, 4'b0001, REQ_FETCH, 1);
    add(0, 4'b1111, 1, 4'b0010, REQ_LSU, 1);
    add(0, 4'b1111, 0, 4'b0010, REQ_LSU, 1);
    add(0, 4'b1111, 1, 4'b0100, REQ_MULDIV, 1);
    add(0, 4'b1111, 0, 4'b0100, REQ_MULDIV, 1);
    add(0, 4'b1111, 1, 4'b1000, REQ_DBG, 1);
    add(0, 4'b1111, 0, 4'b1000, REQ_DBG, 1);
    add(0, 4'b1111, 1, 4'b0001, REQ_FETCH, 1);
    // Owner 1 drops req: grant kept; done with no requests goes idle, sel kept.
    add(0, 4'b0010, 1, 4'b0010, REQ_LSU, 1);
    add(0, 4'b0000, 0, 4'b0010, REQ_LSU, 1);
    add(0, 4'b0000, 1, 4'b0000, REQ_LSU, 0);
    // Owner 3 ignores other requests until done; handover wraps to 0.
    add(0, 4'b1000, 0, 4'b1000, REQ_DBG, 1);
    add(0, 4'b1001, 0, 4'b1000, REQ_DBG, 1);
    add(0, 4'b1001, 1, 4'b0001, REQ_FETCH, 1);
    // Reset during an access with done high, then first grant from ptr 0.
    add(1, 4'b1111, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b0110, 0, 4'b0010, REQ_LSU, 1);
    // Owner re-requesting at done is masked once, wins the following cycle.
    add(0, 4'b0010, 1, 4'b0000, REQ_LSU, 0);
    add(0, 4'b0010, 0, 4'b0010, REQ_LSU, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; done = vecs[i].done;
      #2;
      if (!vecs[i].rst) check($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_sel", i), sel, vecs[i].sel);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Fairness: requester 3 with everyone requesting and done every cycle is
    // reached after at most three other accesses (grant on the 4th edge).
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0; req = 4'b1111; done = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (gnt[3]) break;
    end
    check("max_wait_edges", cnt, 4);
    check("max_wait_sel", sel, REQ_DBG);

    // Randomized traffic against the model.
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    @(posedge clk); #1;
    model_step(req, done, rst);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] exp_gnt;
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      #2;
      if (!rst) check("rnd_timeout", timeout, model_timeout(done));
      @(posedge clk); #1;
      model_step(req, done, rst);
      exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
      check("rnd_gnt", gnt, exp_gnt);
      check("rnd_sel", sel, m_sel);
      check("rnd_busy", busy, m_owner >= 0);
    end
    rst = 1'b0; req = 4'b0000; done = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: owner 0 never gets done; pulse in the 4th owned cycle, then
    // handover to requester 1.
    rst4 = 1'b1; @(posedge clk); #1;
    rst4 = 1'b0; req4 = 4'b0001; done4 = 1'b0;
    @(posedge clk); #1;
    check("to_first_gnt", gnt4, 4'b0001);
    req4 = 4'b0011;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("to_pulse_c%0d", c), timeout4, c == 4);
      check($sformatf("to_hold_c%0d", c), gnt4, 4'b0001);
      @(posedge clk); #1;
    end
    check("to_handover_gnt", gnt4, 4'b0010);
    check("to_handover_sel", sel4, REQ_LSU);
    #1;
    check("to_pulse_after", timeout4, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
